// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with the signs reapplied when the result is registered.
//
// state | meaning
// IDLE  | ready for a request (div_ready=1)
// CALC  | shift-subtract iterations running (WIDTH cycles)
// DONE  | result presented (out_valid=1), waiting for out_ready
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 op_signed;
    logic                 sx;
    logic                 sy;
    logic [WIDTH-1:0]     abs_y;
    logic [2*WIDTH-1:0]   rem;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     abs_x_in;
    logic [WIDTH-1:0]     abs_y_in;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]     quo_mag;
    logic [WIDTH-1:0]     rmd_mag;
    logic                 last_step;
    logic                 accept;

    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = div_valid && div_ready && !cancel;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes; only negated when the operation is signed and the MSB is set
    always_comb begin
        abs_x_in = x;
        abs_y_in = y;
        if (div_signed && x[WIDTH-1]) begin
            abs_x_in = -x;
        end
        if (div_signed && y[WIDTH-1]) begin
            abs_y_in = -y;
        end
    end

    // One restoring step; the shifted-out MSB takes part in the trial subtraction
    always_comb begin
        shifted  = {rem, 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, abs_y};
        rem_next = shifted[2*WIDTH-1:0];
        if (!trial[WIDTH]) begin
            rem_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end
        quo_mag = rem_next[WIDTH-1:0];
        rmd_mag = rem_next[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cancel overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (div_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next = IDLE;
        end
    end

    // Operand capture, iteration datapath and signed result registration
    always_ff @(posedge clk) begin
        if (reset) begin
            op_signed <= 1'b0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            abs_y     <= '0;
            rem       <= '0;
            cnt       <= '0;
            q         <= '0;
            r         <= '0;
        end else if (accept) begin
            op_signed <= div_signed;
            sx        <= x[WIDTH-1];
            sy        <= y[WIDTH-1];
            abs_y     <= abs_y_in;
            rem       <= {{WIDTH{1'b0}}, abs_x_in};
            cnt       <= '0;
        end else if (state == CALC && !cancel) begin
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                q <= (op_signed && (sx ^ sy)) ? -quo_mag : quo_mag;
                r <= (op_signed && sx) ? -rmd_mag : rmd_mag;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: arithmetic corner cases, latency, backpressure,
// cancel and reset during an operation.
module tb_div_iter;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [31:0] r;

    int vectors;
    int miscompares;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .r          (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after the accepting edge, scrambling
    // the operand inputs afterwards to show they are no longer observed.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!div_ready && guard < 100) begin
            tick();
            guard++;
        end
        div_valid  = 1'b1;
        div_signed = s;
        x          = a;
        y          = b;
        tick();
        div_valid  = 1'b0;
        div_signed = ~s;
        x          = $urandom;
        y          = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (div_ready !== 1'b1 || out_valid !== 1'b0 || q !== 32'h0 || r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: ready=%b valid=%b q=%h r=%h, want 1 0 0 0", div_ready, out_valid, q, r);
        end
    endtask

    task automatic test_signed_basic();
        int cyc;
        start_op(1'b1, 32'd100, 32'd7);
        vectors++;
        if (div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_accept: got %b want 0", div_ready);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 32) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles want 32", cyc);
        end
        vectors++;
        if (q !== 32'h0000000E || r !== 32'h00000002) begin
            miscompares++;
            $display("FAIL s_100_div_7: got q=%h r=%h want q=0000000e r=00000002", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1 || q !== 32'h0000000E) begin
            miscompares++;
            $display("FAIL consume: valid=%b ready=%b q=%h want 0 1 0000000e", out_valid, div_ready, q);
        end
    endtask

    task automatic test_neg_and_unsigned();
        int cyc;
        start_op(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        vectors++;
        if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL s_m7_div_2: got q=%h r=%h want q=fffffffd r=ffffffff", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start_op(1'b0, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        vectors++;
        if (q !== 32'h7FFFFFFC || r !== 32'h00000001) begin
            miscompares++;
            $display("FAIL u_fff9_div_2: got q=%h r=%h want q=7ffffffc r=00000001", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int cyc;
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc);
        vectors++;
        if (q !== 32'h80000000 || r !== 32'h00000000) begin
            miscompares++;
            $display("FAIL s_overflow: got q=%h r=%h want q=80000000 r=00000000", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        int cyc;
        start_op(1'b0, 32'h12345678, 32'h0);
        wait_done(cyc);
        vectors++;
        if (q !== 32'hFFFFFFFF || r !== 32'h12345678 || cyc !== 32) begin
            miscompares++;
            $display("FAIL u_div_zero: got q=%h r=%h cyc=%0d want ffffffff 12345678 32", q, r, cyc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start_op(1'b1, 32'h12345678, 32'h0);
        wait_done(cyc);
        vectors++;
        if (q !== 32'hFFFFFFFF || r !== 32'h12345678) begin
            miscompares++;
            $display("FAIL s_div_zero_pos: got q=%h r=%h want ffffffff 12345678", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start_op(1'b1, 32'hFFFFFF00, 32'h0);
        wait_done(cyc);
        vectors++;
        if (q !== 32'h00000001 || r !== 32'hFFFFFF00) begin
            miscompares++;
            $display("FAIL s_div_zero_neg: got q=%h r=%h want 00000001 ffffff00", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(1'b0, 32'd1000, 32'd7);
        wait_done(cyc);
        out_ready = 1'b0;
        div_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || div_ready !== 1'b0 || q !== 32'd142 || r !== 32'd6) begin
                miscompares++;
                $display("FAIL hold_%0d: valid=%b ready=%b q=%h r=%h want 1 0 0000008e 00000006",
                         i, out_valid, div_ready, q, r);
            end
        end
        div_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1 || q !== 32'd142 || r !== 32'd6) begin
            miscompares++;
            $display("FAIL release: valid=%b ready=%b q=%h r=%h want 0 1 0000008e 00000006",
                     out_valid, div_ready, q, r);
        end
    endtask

    task automatic test_cancel();
        int seen;
        int cyc;
        start_op(1'b1, 32'd500, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        cancel    = 1'b1;
        div_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        cancel    = 1'b0;
        div_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_idle: ready=%b valid=%b want 1 0", div_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || !div_ready) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL cancel_quiet: got %0d busy/valid cycles want 0", seen);
        end
        start_op(1'b0, 32'd9, 32'd3);
        wait_done(cyc);
        vectors++;
        if (q !== 32'd3 || r !== 32'd0 || cyc !== 32) begin
            miscompares++;
            $display("FAIL after_cancel_9_div_3: got q=%h r=%h cyc=%0d want 3 0 32", q, r, cyc);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1 || q !== 32'd3) begin
            miscompares++;
            $display("FAIL cancel_done: valid=%b ready=%b q=%h want 0 1 00000003", out_valid, div_ready, q);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(1'b0, 32'd1000, 32'd10);
        wait_done(cyc);
        vectors++;
        if (q !== 32'd100 || r !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_first: got q=%h r=%h want 00000064 00000000", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (div_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_idle: ready=%b want 1", div_ready);
        end
        start_op(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_done(cyc);
        vectors++;
        if (q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE || cyc !== 32) begin
            miscompares++;
            $display("FAIL b2b_second: got q=%h r=%h cyc=%0d want fffffff2 fffffffe 32", q, r, cyc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        int cyc;
        start_op(1'b0, 32'd77, 32'd5);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (div_ready !== 1'b1 || out_valid !== 1'b0 || q !== 32'h0 || r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: ready=%b valid=%b q=%h r=%h want 1 0 0 0", div_ready, out_valid, q, r);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || !div_ready) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_quiet: got %0d busy/valid cycles want 0", seen);
        end
        start_op(1'b0, 32'd9, 32'd3);
        wait_done(cyc);
        vectors++;
        if (q !== 32'd3 || r !== 32'd0) begin
            miscompares++;
            $display("FAIL after_reset_9_div_3: got q=%h r=%h want 3 0", q, r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        div_valid   = 1'b0;
        div_signed  = 1'b0;
        x           = '0;
        y           = '0;
        cancel      = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_signed_basic();
        test_neg_and_unsigned();
        test_overflow();
        test_div_zero();
        test_backpressure();
        test_cancel();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
